branch_decision: RTL and testbench

BRANCH_DECISION -- requirements
Module: branch_decision

---
 rtl/branch_decision.sv | 56 +++++
 tb/tb_branch_decision.sv | 108 ++++++++++
 2 files changed

// File: rtl/branch_decision.sv
// branch_decision: registered adder plus RISC-V branch comparator with a one-cycle latency.
// The comparison uses its own subtractor, so cin never affects taken or zero.
module branch_decision #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    input  logic             valid_in,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             taken,
    output logic             valid_out,
    output logic             zero
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           eq;
    logic           ltu;
    logic           lt;
    logic           ovf;
    logic           cond;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        eq   = diff[WIDTH-1:0] == '0;
        // no carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned
        ltu  = ~diff[WIDTH];
        ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]);
        lt   = diff[WIDTH-1] ^ ovf;
        cond = op[2:1] == 2'b01 ? 1'b0 :
               op[2:1] == 2'b00 ? eq ^ op[0] :
               op[2:1] == 2'b10 ? lt ^ op[0] :
                                  ltu ^ op[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            cout      <= 1'b0;
            taken     <= 1'b0;
            valid_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            s         <= sum[WIDTH-1:0];
            cout      <= sum[WIDTH];
            taken     <= cond & valid_in;
            valid_out <= valid_in;
            zero      <= eq;
        end
    end
endmodule

// File: tb/tb_branch_decision.sv
// tb_branch_decision: directed and random checks of branch_decision against an integer reference model.
module tb_branch_decision;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic [2:0] op = '0;
    logic       valid_in = 1'b0;
    logic [3:0] s;
    logic       cout;
    logic       taken;
    logic       valid_out;
    logic       zero;
    int         total = 0;
    int         bad = 0;

    branch_decision #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .op(op),
        .valid_in(valid_in), .s(s), .cout(cout), .taken(taken),
        .valid_out(valid_out), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s"}, 32'(s), 0);
        check({tag, "_cout"}, 32'(cout), 0);
        check({tag, "_taken"}, 32'(taken), 0);
        check({tag, "_vout"}, 32'(valid_out), 0);
        check({tag, "_zero"}, 32'(zero), 0);
    endtask

    // Reference: plain integer arithmetic, signed view via two's complement offset
    task automatic step(input string tag, input int ta, input int tb, input int tc,
                        input int top, input int tv);
        int sum, sa, sb, c;
        a = 4'(ta); b = 4'(tb); cin = 1'(tc); op = 3'(top); valid_in = 1'(tv);
        sum = ta + tb + tc;
        sa = ta >= 8 ? ta - 16 : ta;
        sb = tb >= 8 ? tb - 16 : tb;
        case (top)
            0: c = int'(ta == tb);
            1: c = int'(ta != tb);
            4: c = int'(sa < sb);
            5: c = int'(sa >= sb);
            6: c = int'(ta < tb);
            7: c = int'(ta >= tb);
            default: c = 0;
        endcase
        @(posedge clk);
        #1;
        check({tag, "_s"}, 32'(s), 32'(sum % 16));
        check({tag, "_cout"}, 32'(cout), 32'(sum >= 16));
        check({tag, "_taken"}, 32'(taken), 32'(c & tv));
        check({tag, "_vout"}, 32'(valid_out), 32'(tv));
        check({tag, "_zero"}, 32'(zero), 32'(ta == tb));
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        step("f5_blt", 15, 5, 0, 4, 1);
        step("f5_bltu", 15, 5, 0, 6, 1);
        step("9e", 9, 14, 0, 0, 1);
        step("1d", 1, 13, 0, 1, 1);
        step("71_bge", 7, 1, 0, 5, 1);
        step("71_beq", 7, 1, 0, 0, 1);
        step("66_beq", 6, 6, 0, 0, 1);
        step("66_bne", 6, 6, 0, 1, 1);
        step("66_op2", 6, 6, 0, 2, 1);
        step("66_op3", 6, 6, 1, 3, 1);
        step("66_bge", 6, 6, 0, 5, 1);
        step("66_bgeu", 6, 6, 0, 7, 1);
        step("66_blt", 6, 6, 0, 4, 1);
        step("66_bltu", 6, 6, 0, 6, 1);
        step("87_blt", 8, 7, 0, 4, 1);
        step("87_bltu", 8, 7, 0, 6, 1);
        step("ff_cin", 15, 15, 1, 0, 1);
        step("novalid", 15, 15, 0, 0, 0);
        // mid-cycle reset with a taken request already registered and another pending
        step("pre_rst", 3, 3, 0, 0, 1);
        a = 4'd3; b = 4'd9; cin = 1'b1; op = 3'd6; valid_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        step("post_rst", 3, 9, 1, 6, 1);
        for (int i = 0; i < 200; i++)
            step("rand", int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(1)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
